fsld_loader: RTL
================

// Module: fsld_loader
// PURPOSE
//   First-load engine for SRAM0 in the 64-MAC DLA. Consumes the master FSM state. While the
//   state is FSLD (3'd7), it accepts a valid/ready input stream and writes LOAD_WORDS words
//   round-robin across NUM_BANKS SRAM0 banks. It then pulses flag_fsld_end to the master FSM,
//   which moves FSLD -> LEFT.
// PARAMETERS
//   DATA_W      64   width of one stream word / SRAM word
//   NUM_BANKS   8    SRAM0 banks, written round-robin (power of 2)
//   LOAD_WORDS  512  words per first load; must be a multiple of NUM_BANKS
//   ADDR_W      6    bank address width; must be >= clog2(LOAD_WORDS/NUM_BANKS)
//   CNT_W       10   word-counter width; must be clog2(LOAD_WORDS+1)
// PORTS
//   clk            in   1          clock, rising edge
//   reset          in   1          synchronous, active-high
//   mast_state     in   3          master FSM current state; FSLD = 3'd7
//   s_valid        in   1          input word valid
//   s_data         in   DATA_W     input word
//   s_ready        out  1          loader can accept a word this cycle
//   sram_we        out  NUM_BANKS  one-hot bank write enable, registered
//   sram_addr      out  ADDR_W     bank address, registered
//   sram_wdata     out  DATA_W     write data, registered
//   flag_fsld_end  out  1          one-cycle pulse: the last word has been written
//   load_cnt       out  CNT_W      words accepted so far in the current load
// BEHAVIOUR
//   Reset: state=L_IDLE; s_ready, sram_we, sram_addr, sram_wdata, flag_fsld_end and
//     load_cnt are all 0.
//   Internal FSM:
//     L_IDLE -> L_LOAD when mast_state==FSLD; load_cnt cleared on entry.
//     L_LOAD -> L_DONE on the handshake where load_cnt==LOAD_WORDS-1.
//     L_DONE -> L_IDLE when mast_state!=FSLD.
//   s_ready = (state==L_LOAD) && (mast_state==FSLD), combinational. It is 0 in L_IDLE and L_DONE.
//   Handshake: a word transfers on a cycle where s_valid && s_ready. s_valid may drop
//     at any time; no bubbles are inserted by the loader itself.
//   Mapping for accepted word n (n = load_cnt before increment):
//     bank = n % NUM_BANKS; addr = n / NUM_BANKS; use bit slicing, no divider.
//   Latency: handshake at cycle T -> sram_we[bank]=1 with addr and data at T+1.
//     sram_we is 0 on cycles following no handshake. sram_addr and sram_wdata hold their
//     last values.
//   flag_fsld_end: 1 for exactly one cycle, at T+1 of the last handshake, coincident with
//     the last write. It is never re-asserted while in L_DONE.
//   load_cnt increments by 1 per handshake and saturates at LOAD_WORDS. It holds in L_DONE
//     and clears on L_IDLE -> L_LOAD.
//   Abort: if mast_state leaves FSLD while in L_LOAD:
//     - go to L_IDLE and drop s_ready the same cycle;
//     - a write already registered still completes;
//     - no flag pulse is issued.
//     A later FSLD entry restarts from word 0.
//   Reset mid-load: takes effect at the next edge and overrides everything. No write or
//     flag is issued on the cycle after reset is asserted.
//   Non-FSLD states (IDLE, LEFT, BASE, RIGHT, others) never cause writes.
// TESTING
//   1 Reset, mast_state=7, s_valid=1 continuously:
//     -> 512 writes on consecutive cycles; the first is bank0/addr0;
//     -> word 9 goes to bank1/addr1; the last is bank7/addr63;
//     -> flag_fsld_end pulses once, coincident with the last sram_we;
//     -> load_cnt=512.
//   2 Same as 1 with s_valid toggling 1,0,1,0:
//     -> 512 writes with gaps;
//     -> data order preserved: sram_wdata == word index written;
//     -> flag occurs about 1023 cycles after the first handshake.
//   3 mast_state drops to 1 after 100 handshakes:
//     -> s_ready=0 that cycle; no more writes after the pending one; no flag;
//     -> re-enter FSLD -> writes restart at bank0/addr0 with load_cnt=0.
//   4 Remain in FSLD for 20 cycles after the flag with s_valid=1:
//     -> s_ready=0, no writes, no second flag;
//     -> mast_state=1 -> L_IDLE.
//   5 Assert reset at handshake 300:
//     -> next cycle all outputs 0 and state L_IDLE;
//     -> with mast_state=7 after release, the load restarts from word 0.
//   6 Parameter run: NUM_BANKS=4, LOAD_WORDS=16, ADDR_W=2, CNT_W=5:
//     -> word 5 goes to bank1/addr1;
//     -> flag comes with the 16th write.

Source files
------------

// File: rtl/fsld_loader_if.sv
// Stream-in and SRAM0 write-port bundle for the first-load engine.
// master = the side feeding words and watching the SRAM writes; slave = the loader.
interface fsld_loader_if #(
  parameter int DATA_W    = 64,
  parameter int NUM_BANKS = 8,
  parameter int ADDR_W    = 6,
  parameter int CNT_W     = 10
);
  logic [2:0]           mast_state;
  logic                 s_valid;
  logic [DATA_W-1:0]    s_data;
  logic                 s_ready;
  logic [NUM_BANKS-1:0] sram_we;
  logic [ADDR_W-1:0]    sram_addr;
  logic [DATA_W-1:0]    sram_wdata;
  logic                 flag_fsld_end;
  logic [CNT_W-1:0]     load_cnt;

  modport master (
    output mast_state, s_valid, s_data,
    input  s_ready, sram_we, sram_addr, sram_wdata, flag_fsld_end, load_cnt
  );

  modport slave (
    input  mast_state, s_valid, s_data,
    output s_ready, sram_we, sram_addr, sram_wdata, flag_fsld_end, load_cnt
  );
endinterface

// File: rtl/fsld_loader.sv
// SRAM0 first-load engine: streams LOAD_WORDS words round-robin over the banks while the master is in FSLD.
// Writes and the end flag appear one cycle after the handshake; s_ready is combinational and drops the cycle FSLD is left.
module fsld_loader #(
  parameter int DATA_W     = 64,
  parameter int NUM_BANKS  = 8,
  parameter int LOAD_WORDS = 512,
  parameter int ADDR_W     = 6,
  parameter int CNT_W      = 10
) (
  input  logic          clk,
  input  logic          reset,
  fsld_loader_if.slave  io_ld
);

  localparam int               BANK_W = $clog2(NUM_BANKS);
  localparam logic [2:0]       FSLD   = 3'd7;
  localparam logic [CNT_W-1:0] LAST   = CNT_W'(LOAD_WORDS - 1);
  localparam logic [CNT_W-1:0] FULL   = CNT_W'(LOAD_WORDS);

  typedef enum logic [1:0] {
    L_IDLE = 2'd0,
    L_LOAD = 2'd1,
    L_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                 w_in_fsld;
  logic                 w_ready;
  logic                 w_hs;
  logic                 w_last;
  logic                 w_start;
  logic [BANK_W-1:0]    w_bank;
  logic [ADDR_W-1:0]    w_addr;

  logic [NUM_BANKS-1:0] r_we;
  logic [ADDR_W-1:0]    r_addr;
  logic [DATA_W-1:0]    r_wdata;
  logic                 r_flag;
  logic [CNT_W-1:0]     r_cnt;

  assign w_in_fsld = (io_ld.mast_state == FSLD);
  assign w_hs      = io_ld.s_valid && w_ready;
  assign w_last    = w_hs && (r_cnt == LAST);

  // Power-of-two bank count: low counter bits pick the bank, the next bits the row.
  assign w_bank = r_cnt[BANK_W-1:0];
  assign w_addr = r_cnt[BANK_W +: ADDR_W];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= L_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_start     = 1'b0;
    case (r_state)
      L_IDLE: begin
        if (w_in_fsld) begin
          w_state_nxt = L_LOAD;
          w_start     = 1'b1;
        end
      end
      L_LOAD: begin
        w_ready = w_in_fsld;
        if (!w_in_fsld) begin
          w_state_nxt = L_IDLE;
        end else if (w_last) begin
          w_state_nxt = L_DONE;
        end
      end
      L_DONE: begin
        if (!w_in_fsld) begin
          w_state_nxt = L_IDLE;
        end
      end
      default: begin
        w_state_nxt = L_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_we    <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_flag  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_we   <= '0;
      r_flag <= 1'b0;
      if (w_hs) begin
        r_we    <= NUM_BANKS'(1) << w_bank;
        r_addr  <= w_addr;
        r_wdata <= io_ld.s_data;
        r_flag  <= w_last;
      end
      // Count survives an abort until the next FSLD entry restarts the load.
      if (w_start) begin
        r_cnt <= '0;
      end else if (w_hs && (r_cnt != FULL)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign io_ld.s_ready       = w_ready;
  assign io_ld.sram_we       = r_we;
  assign io_ld.sram_addr     = r_addr;
  assign io_ld.sram_wdata    = r_wdata;
  assign io_ld.flag_fsld_end = r_flag;
  assign io_ld.load_cnt      = r_cnt;

endmodule
